// File: rtl/dice_pkg.sv
// Shared constants for the dice roller: die limits, display FSM encodings,
// seven-segment digit patterns (gfedcba, active-high) and range helpers.
package dice_pkg;

  localparam logic [4:0] D6_MAX  = 5'd6;
  localparam logic [4:0] D20_MAX = 5'd20;

  typedef enum logic [1:0] {
    BLANK = 2'b00,
    SPIN  = 2'b01,
    SHOW  = 2'b10
  } disp_state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Highest face of the selected die (d20 when the mode bit is set).
  function automatic logic [4:0] die_max(input logic d20);
    return d20 ? D20_MAX : D6_MAX;
  endfunction

  // A roll is legal when it lies in 1..max for the selected die.
  function automatic logic value_in_range(input logic [4:0] v, input logic d20);
    return (v != 5'd0) && (v <= die_max(d20));
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational decimal digit to seven-segment (gfedcba) encoder with a
// blanking input that darkens the digit regardless of its value.
module seg7_encode
  import dice_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern_s;

  // Look up the segment pattern for a decimal digit; non-decimal codes stay dark
  always_comb begin
    pattern_s = 7'h00;
    case (digit)
      4'd0:    pattern_s = SEG_0;
      4'd1:    pattern_s = SEG_1;
      4'd2:    pattern_s = SEG_2;
      4'd3:    pattern_s = SEG_3;
      4'd4:    pattern_s = SEG_4;
      4'd5:    pattern_s = SEG_5;
      4'd6:    pattern_s = SEG_6;
      4'd7:    pattern_s = SEG_7;
      4'd8:    pattern_s = SEG_8;
      4'd9:    pattern_s = SEG_9;
      default: pattern_s = 7'h00;
    endcase
  end

  // Apply blanking on top of the looked-up pattern
  always_comb begin
    seg = 7'h00;
    if (blank) begin
      seg = 7'h00;
    end else begin
      seg = pattern_s;
    end
  end

endmodule

// File: rtl/dice_display_driver.sv
// Display stage for the dice roller: accepts in-range rolls, plays a short
// spin animation, then shows the held roll on a two-digit multiplexed
// seven-segment display with leading-zero blanking and a critical-roll flag.
// All outputs are registered from next-state values so that dig_en and seg
// always change together on the same edge.
module dice_display_driver
  import dice_pkg::*;
#(
  parameter int REFRESH_DIV = 1024,
  parameter int SPIN_CYCLES = 4096,
  parameter int SPIN_STEP   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] value_in,
  input  logic       value_valid,
  input  logic       twty_mode,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       busy,
  output logic       crit
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SPIN_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
  localparam int STEP_W = (SPIN_STEP > 1)   ? $clog2(SPIN_STEP)   : 1;

  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SPIN_W-1:0] SPIN_LOAD = SPIN_W'(SPIN_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPIN_STEP - 1);

  // State and datapath registers
  disp_state_e       state_r;
  logic [4:0]        held_r;
  logic              mode_r;
  logic [SPIN_W-1:0] spin_cnt_r;
  logic [STEP_W-1:0] step_cnt_r;
  logic [4:0]        spin_val_r;
  logic [REF_W-1:0]  refresh_cnt_r;
  logic              sel_r;

  // Registered outputs
  logic [6:0]        seg_r;
  logic [1:0]        dig_en_r;
  logic              busy_r;
  logic              crit_r;

  // Next-state values
  logic              accept_s;
  disp_state_e       state_nx_s;
  logic [4:0]        held_nx_s;
  logic              mode_nx_s;
  logic [SPIN_W-1:0] spin_cnt_nx_s;
  logic [STEP_W-1:0] step_cnt_nx_s;
  logic [4:0]        spin_val_nx_s;
  logic [REF_W-1:0]  refresh_cnt_nx_s;
  logic              sel_nx_s;

  // Display datapath
  logic [4:0]        disp_val_s;
  logic [1:0]        tens_s;
  logic [3:0]        ones_s;
  logic [3:0]        digit_s;
  logic              blank_s;
  logic              active_s;
  logic [6:0]        seg_nx_s;
  logic [1:0]        dig_en_nx_s;
  logic              busy_nx_s;
  logic              crit_nx_s;

  // FSM next state, accept handling and spin animation counters
  always_comb begin
    accept_s      = value_valid && value_in_range(value_in, twty_mode);
    state_nx_s    = state_r;
    held_nx_s     = held_r;
    mode_nx_s     = mode_r;
    spin_cnt_nx_s = spin_cnt_r;
    step_cnt_nx_s = step_cnt_r;
    spin_val_nx_s = spin_val_r;
    if (accept_s) begin
      // An accept always wins, including on the last spin cycle
      state_nx_s    = SPIN;
      held_nx_s     = value_in;
      mode_nx_s     = twty_mode;
      spin_cnt_nx_s = SPIN_LOAD;
      step_cnt_nx_s = '0;
      spin_val_nx_s = 5'd1;
    end else begin
      case (state_r)
        BLANK: begin
          state_nx_s = BLANK;
        end
        SPIN: begin
          if (spin_cnt_r == '0) begin
            state_nx_s = SHOW;
          end else begin
            state_nx_s    = SPIN;
            spin_cnt_nx_s = spin_cnt_r - SPIN_W'(1);
          end
          if (step_cnt_r == STEP_LAST) begin
            step_cnt_nx_s = '0;
            if (spin_val_r >= die_max(mode_r)) begin
              spin_val_nx_s = 5'd1;
            end else begin
              spin_val_nx_s = spin_val_r + 5'd1;
            end
          end else begin
            step_cnt_nx_s = step_cnt_r + STEP_W'(1);
          end
        end
        SHOW: begin
          state_nx_s = SHOW;
        end
        default: begin
          state_nx_s = BLANK;
        end
      endcase
    end
  end

  // Refresh divider that toggles the digit select on every wrap
  always_comb begin
    refresh_cnt_nx_s = refresh_cnt_r;
    sel_nx_s         = sel_r;
    if (refresh_cnt_r == REF_LAST) begin
      refresh_cnt_nx_s = '0;
      sel_nx_s         = ~sel_r;
    end else begin
      refresh_cnt_nx_s = refresh_cnt_r + REF_W'(1);
      sel_nx_s         = sel_r;
    end
  end

  // Pick the value shown next: animation value while spinning, held roll after
  always_comb begin
    disp_val_s = 5'd0;
    case (state_nx_s)
      SPIN:    disp_val_s = spin_val_nx_s;
      SHOW:    disp_val_s = held_nx_s;
      default: disp_val_s = 5'd0;
    endcase
  end

  // Split the displayed value (at most 20) into tens and ones digits
  always_comb begin
    tens_s = 2'd0;
    ones_s = 4'd0;
    if (disp_val_s >= 5'd20) begin
      tens_s = 2'd2;
      ones_s = 4'(disp_val_s - 5'd20);
    end else if (disp_val_s >= 5'd10) begin
      tens_s = 2'd1;
      ones_s = 4'(disp_val_s - 5'd10);
    end else begin
      tens_s = 2'd0;
      ones_s = 4'(disp_val_s);
    end
  end

  // Choose the digit for the next enabled position and the status flags
  always_comb begin
    active_s    = (state_nx_s != BLANK);
    digit_s     = ones_s;
    blank_s     = ~active_s;
    dig_en_nx_s = 2'b00;
    if (sel_nx_s) begin
      digit_s = {2'b00, tens_s};
      blank_s = ~active_s || (tens_s == 2'd0);
    end else begin
      digit_s = ones_s;
      blank_s = ~active_s;
    end
    if (active_s) begin
      dig_en_nx_s = sel_nx_s ? 2'b10 : 2'b01;
    end else begin
      dig_en_nx_s = 2'b00;
    end
    busy_nx_s = (state_nx_s == SPIN);
    crit_nx_s = (state_nx_s == SHOW) && (held_nx_s == die_max(mode_nx_s));
  end

  seg7_encode u_seg7 (
    .digit (digit_s),
    .blank (blank_s),
    .seg   (seg_nx_s)
  );

  // FSM, counters and held roll registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= BLANK;
      held_r        <= 5'd0;
      mode_r        <= 1'b0;
      spin_cnt_r    <= '0;
      step_cnt_r    <= '0;
      spin_val_r    <= 5'd0;
      refresh_cnt_r <= '0;
      sel_r         <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      held_r        <= held_nx_s;
      mode_r        <= mode_nx_s;
      spin_cnt_r    <= spin_cnt_nx_s;
      step_cnt_r    <= step_cnt_nx_s;
      spin_val_r    <= spin_val_nx_s;
      refresh_cnt_r <= refresh_cnt_nx_s;
      sel_r         <= sel_nx_s;
    end
  end

  // Output registers, loaded from next-state values so digit and segments align
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r    <= 7'h00;
      dig_en_r <= 2'b00;
      busy_r   <= 1'b0;
      crit_r   <= 1'b0;
    end else begin
      seg_r    <= seg_nx_s;
      dig_en_r <= dig_en_nx_s;
      busy_r   <= busy_nx_s;
      crit_r   <= crit_nx_s;
    end
  end

  assign seg    = seg_r;
  assign dig_en = dig_en_r;
  assign busy   = busy_r;
  assign crit   = crit_r;

endmodule

// File: tb/tb_dice_display_driver.sv
// Scoreboard bench for dice_display_driver with REFRESH_DIV=4, SPIN_CYCLES=16,
// SPIN_STEP=4. Stimulus pushes hand-computed expectations tagged with the
// cycle (posedges since reset release) at which they must hold; a monitor
// pops and compares them on the falling edge.
module tb_dice_display_driver;

  logic       clk;
  logic       rst_n;
  logic [4:0] value_in;
  logic       value_valid;
  logic       twty_mode;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       busy;
  logic       crit;

  dice_display_driver #(
    .REFRESH_DIV (4),
    .SPIN_CYCLES (16),
    .SPIN_STEP   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .twty_mode   (twty_mode),
    .seg         (seg),
    .dig_en      (dig_en),
    .busy        (busy),
    .crit        (crit)
  );

  typedef struct packed {
    int          cyc;
    logic        is_async;
    logic        act;
    logic [6:0]  seg_ones;
    logic [6:0]  seg_tens;
    logic        b;
    logic        c;
    logic [6:0]  cap_seg;
    logic [1:0]  cap_dig;
    logic        cap_busy;
    logic        cap_crit;
    logic [95:0] nm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc;
  int         checks;
  int         failures;
  int         mon_cycles;
  logic [1:0] exp_dig;
  logic [6:0] exp_seg;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count active edges since reset release; the digit phase follows this count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int k, input logic act, input logic [6:0] so,
                      input logic [6:0] st, input logic b, input logic c,
                      input logic [95:0] nm);
    exp_t e;
    e          = '0;
    e.cyc      = k;
    e.act      = act;
    e.seg_ones = so;
    e.seg_tens = st;
    e.b        = b;
    e.c        = c;
    e.nm       = nm;
    sb_q.push_back(e);
  endtask

  // Spin with strobe seen at edge k0+1: value (j-1)/4+1 after edge k0+j
  task automatic push_spin(input int k0, input int jlo, input int jhi, input logic [95:0] nm);
    for (int j = jlo; j <= jhi; j++)
      push(k0 + j, 1'b1, segtab[(j - 1) / 4 + 1], 7'h00, 1'b1, 1'b0, nm);
  endtask

  task automatic push_show(input int from, input int to, input logic [6:0] so,
                           input logic [6:0] st, input logic c, input logic [95:0] nm);
    for (int k = from; k <= to; k++) push(k, 1'b1, so, st, 1'b0, c, nm);
  endtask

  task automatic push_blank(input int from, input int to, input logic [95:0] nm);
    for (int k = from; k <= to; k++) push(k, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0, nm);
  endtask

  task automatic strobe(input logic [4:0] v, input logic m, output int k0);
    k0          = cyc;
    value_in    = v;
    value_valid = 1'b1;
    twty_mode   = m;
  endtask

  task automatic end_strobe();
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drop rst_n between edges, capture outputs immediately, then release
  task automatic async_reset_check(input logic [95:0] nm);
    exp_t e;
    int   guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    e          = '0;
    e.is_async = 1'b1;
    e.cap_seg  = seg;
    e.cap_dig  = dig_en;
    e.cap_busy = busy;
    e.cap_crit = crit;
    e.nm       = nm;
    sb_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_blank(1, 6, "post_reset");
    wait_cyc(6);
  endtask

  // Monitor: pop every expectation that is due and compare with the outputs
  initial begin
    checks     = 0;
    failures   = 0;
    mon_cycles = 0;
    forever begin
      @(negedge clk);
      mon_cycles++;
      if (mon_cycles > 5000) begin
        failures++;
        $display("FAIL watchdog: cycle budget expired with %0d entries pending", sb_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped by watchdog");
      end
      while (sb_q.size() > 0 && (sb_q[0].is_async || sb_q[0].cyc <= cyc)) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (mon_e.is_async) begin
          if (mon_e.cap_seg !== 7'h00 || mon_e.cap_dig !== 2'b00 ||
              mon_e.cap_busy !== 1'b0 || mon_e.cap_crit !== 1'b0) begin
            failures++;
            $display("FAIL %s: right after rst_n fell seg=%h dig_en=%b busy=%b crit=%b, expected seg=00 dig_en=00 busy=0 crit=0",
                     mon_e.nm, mon_e.cap_seg, mon_e.cap_dig, mon_e.cap_busy, mon_e.cap_crit);
          end
        end else begin
          if (!mon_e.act)                  exp_dig = 2'b00;
          else if (((mon_e.cyc / 4) % 2) == 1) exp_dig = 2'b10;
          else                             exp_dig = 2'b01;
          if (exp_dig == 2'b10)      exp_seg = mon_e.seg_tens;
          else if (exp_dig == 2'b01) exp_seg = mon_e.seg_ones;
          else                       exp_seg = 7'h00;
          if (mon_e.cyc != cyc || seg !== exp_seg || dig_en !== exp_dig ||
              busy !== mon_e.b || crit !== mon_e.c) begin
            failures++;
            $display("FAIL %s at cycle %0d (now %0d): seg=%h dig_en=%b busy=%b crit=%b, expected seg=%h dig_en=%b busy=%b crit=%b",
                     mon_e.nm, mon_e.cyc, cyc, seg, dig_en, busy, crit,
                     exp_seg, exp_dig, mon_e.b, mon_e.c);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int k0;
    int k1;
    int guard;
    rst_n       = 1'b0;
    value_in    = 5'd0;
    value_valid = 1'b0;
    twty_mode   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_blank(1, 6, "reset_idle");
    wait_cyc(6);

    // d6 roll of 6: spin 1,2,3,4 then "6" with crit
    strobe(5'd6, 1'b0, k0);
    push_spin(k0, 1, 16, "d6_spin");
    push_show(k0 + 17, k0 + 24, 7'h7D, 7'h00, 1'b1, "d6_show6");
    end_strobe();
    wait_cyc(k0 + 24);

    // Reach SHOW(3), then present out-of-range strobes
    strobe(5'd3, 1'b0, k0);
    push_spin(k0, 1, 16, "d6_spin3");
    push_show(k0 + 17, k0 + 20, 7'h4F, 7'h00, 1'b0, "d6_show3");
    end_strobe();
    wait_cyc(k0 + 20);
    strobe(5'd7, 1'b0, k0);
    push_show(k0 + 1, k0 + 4, 7'h4F, 7'h00, 1'b0, "oor_d6_7");
    end_strobe();
    wait_cyc(k0 + 4);
    strobe(5'd0, 1'b1, k0);
    push_show(k0 + 1, k0 + 3, 7'h4F, 7'h00, 1'b0, "oor_d20_0");
    end_strobe();
    wait_cyc(k0 + 3);
    strobe(5'd21, 1'b1, k0);
    push_show(k0 + 1, k0 + 3, 7'h4F, 7'h00, 1'b0, "oor_d20_21");
    end_strobe();
    wait_cyc(k0 + 3);

    // d20 roll of 17
    strobe(5'd17, 1'b1, k0);
    push_spin(k0, 1, 16, "d20_spin17");
    push_show(k0 + 17, k0 + 28, 7'h07, 7'h06, 1'b0, "d20_show17");
    end_strobe();
    wait_cyc(k0 + 28);

    // d20 roll of 10: ones digit 0 must not be blanked
    strobe(5'd10, 1'b1, k0);
    push_show(k0 + 17, k0 + 24, 7'h3F, 7'h06, 1'b0, "d20_show10");
    end_strobe();
    wait_cyc(k0 + 24);

    // Restart: 20 arrives 10 cycles into a spin of 9
    strobe(5'd9, 1'b1, k0);
    push_spin(k0, 1, 10, "restart_a");
    end_strobe();
    wait_cyc(k0 + 10);
    strobe(5'd20, 1'b1, k1);
    push_spin(k1, 1, 16, "restart_b");
    push_show(k1 + 17, k1 + 24, 7'h3F, 7'h5B, 1'b1, "show20");
    end_strobe();
    wait_cyc(k1 + 24);

    // Mode latch: switching to d6 during SHOW(20) changes nothing
    twty_mode = 1'b0;
    k0 = cyc;
    push_show(k0 + 1, k0 + 10, 7'h3F, 7'h5B, 1'b1, "mode_latch");
    wait_cyc(k0 + 10);
    strobe(5'd20, 1'b0, k0);
    push_show(k0 + 1, k0 + 4, 7'h3F, 7'h5B, 1'b1, "oor_d6_20");
    end_strobe();
    wait_cyc(k0 + 4);

    // Asynchronous reset while SHOW(20) has crit high
    async_reset_check("rst_show");

    // Accept coinciding with the last spin cycle restarts the spin
    strobe(5'd2, 1'b0, k0);
    push_spin(k0, 1, 16, "lastcyc_a");
    end_strobe();
    wait_cyc(k0 + 16);
    strobe(5'd5, 1'b0, k1);
    push_spin(k1, 1, 16, "lastcyc_b");
    push_show(k1 + 17, k1 + 24, 7'h6D, 7'h00, 1'b0, "show5");
    end_strobe();
    wait_cyc(k1 + 24);

    // Asynchronous reset in the middle of a spin
    strobe(5'd4, 1'b0, k0);
    push_spin(k0, 1, 5, "spin4");
    end_strobe();
    wait_cyc(k0 + 6);
    async_reset_check("rst_spin");

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
